uart_tx_scheduler: RTL and testbench

- Shares one UART transmitter among R byte requesters using round-robin arbitration.
- Sits between the requesters (command/response engines, debug taps) and the uart block's tx_data/transmit inputs.
- The UART exposes no busy flag, so the block paces frames by counting the fixed frame length: start bit, N data bits, stop bit, one bit per clk.
- Guarantees at most one transmit pulse per frame and preserves each requester's byte until it is acknowledged.

---
 rtl/uart_tx_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmitter among R byte requesters,
// pacing frames by counting FRAME + GAP cycles. Optional stats: UART_SCHED_STATS_EN.
module uart_tx_scheduler #(
    parameter int N     = 8,
    parameter int R     = 4,
    parameter int FRAME = 10,
    parameter int GAP   = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*N-1:0] req_data,
    output logic [R-1:0]   ack,
    output logic [N-1:0]   tx_data,
    output logic           transmit,
    output logic           busy,
    output logic [2:0]     grant_id
`ifdef UART_SCHED_STATS_EN
    ,
    output logic [15:0]    frames_sent,
    output logic [7:0]     drop_cnt
`endif
);

    localparam int MAXC = (FRAME > GAP) ? FRAME : GAP;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] FRAME_LOAD = CW'(FRAME - 1);
    localparam logic [CW-1:0] GAP_LOAD   = CW'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     rr_q, rr_d;
    logic [R-1:0]   ack_q, ack_d;
    logic [N-1:0]   tx_data_q, tx_data_d;
    logic           transmit_q, transmit_d;
    logic           busy_q, busy_d;
    logic [2:0]     grant_q, grant_d;

    // Requests and bytes padded to 8 slots so a 3-bit index always fits exactly.
    logic [7:0]     req_ext;
    logic [N-1:0]   data_arr [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < R) begin : g_used
                assign req_ext[gi]  = req[gi];
                assign data_arr[gi] = req_data[gi*N +: N];
            end else begin : g_unused
                assign req_ext[gi]  = 1'b0;
                assign data_arr[gi] = '0;
            end
        end
    endgenerate

    logic       found;
    logic [2:0] win;
    logic [3:0] sum;

    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int i = 0; i < R; i++) begin
            sum = {1'b0, rr_q} + 4'(i);
            if (sum >= 4'(R)) begin
                sum = sum - 4'(R);
            end
            if (!found && req_ext[sum[2:0]]) begin
                found = 1'b1;
                win   = sum[2:0];
            end
        end
    end

    logic [3:0] win_inc;
    logic [7:0] ack_onehot;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_d       = rr_q;
        ack_d      = '0;
        transmit_d = 1'b0;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        win_inc    = {1'b0, win} + 4'd1;
        ack_onehot = 8'd1 << win;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_SEND;
                    cnt_d      = FRAME_LOAD;
                    tx_data_d  = data_arr[win];
                    transmit_d = 1'b1;
                    ack_d      = ack_onehot[R-1:0];
                    grant_d    = win;
                    rr_d       = (win_inc == 4'(R)) ? 3'd0 : win_inc[2:0];
                end
            end
            S_SEND: begin
                if (cnt_q == '0) begin
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rr_q       <= '0;
            ack_q      <= '0;
            tx_data_q  <= '0;
            transmit_q <= 1'b0;
            busy_q     <= 1'b0;
            grant_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            transmit_q <= transmit_d;
            busy_q     <= busy_d;
            grant_q    <= grant_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign transmit = transmit_q;
    assign busy     = busy_q;
    assign grant_id = grant_q;

`ifdef UART_SCHED_STATS_EN
    logic [15:0]  frames_q;
    logic [7:0]   drop_q;
    logic [R-1:0] req_prev_q;
    logic [R-1:0] ack_prev_q;
    logic         drop_evt;

    // A fall is legitimate if the ack was visible this cycle or the one before.
    assign drop_evt = |(req_prev_q & ~req & ~ack_q & ~ack_prev_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_q   <= '0;
            drop_q     <= '0;
            req_prev_q <= '0;
            ack_prev_q <= '0;
        end else begin
            req_prev_q <= req;
            ack_prev_q <= ack_q;
            if (transmit_d) begin
                frames_q <= frames_q + 16'd1;
            end
            if (drop_evt && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign frames_sent = frames_q;
    assign drop_cnt    = drop_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: reset, round-robin order and spacing,
// pointer wrap, frame hold/busy timing, ignored mid-frame requests, GAP=0 spacing.
module tb_uart_tx_scheduler;

    localparam int N = 8;
    localparam int R = 4;

    logic           clk;
    logic           rst;
    logic [R-1:0]   req;
    logic [R*N-1:0] req_data;
    logic [R-1:0]   ack;
    logic [N-1:0]   tx_data;
    logic           transmit;
    logic           busy;
    logic [2:0]     grant_id;

    logic [R-1:0]   req2;
    logic [R*N-1:0] req_data2;
    logic [R-1:0]   ack2;
    logic [N-1:0]   tx_data2;
    logic           transmit2;
    logic           busy2;
    logic [2:0]     grant_id2;

`ifdef UART_SCHED_STATS_EN
    logic [15:0]    frames_sent;
    logic [7:0]     drop_cnt;
    logic [15:0]    frames_sent2;
    logic [7:0]     drop_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(.N(N), .R(R), .FRAME(10), .GAP(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .tx_data  (tx_data),
        .transmit (transmit),
        .busy     (busy),
        .grant_id (grant_id)
`ifdef UART_SCHED_STATS_EN
        ,
        .frames_sent (frames_sent),
        .drop_cnt    (drop_cnt)
`endif
    );

    uart_tx_scheduler #(.N(N), .R(R), .FRAME(10), .GAP(0)) u_gap0 (
        .clk      (clk),
        .rst      (rst),
        .req      (req2),
        .req_data (req_data2),
        .ack      (ack2),
        .tx_data  (tx_data2),
        .transmit (transmit2),
        .busy     (busy2),
        .grant_id (grant_id2)
`ifdef UART_SCHED_STATS_EN
        ,
        .frames_sent (frames_sent2),
        .drop_cnt    (drop_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("check %s ok: 0x%0h", tag, obs);
        end
    endtask

    // Steps at least one cycle, then waits (bounded) for a transmit pulse.
    task automatic wait_tx(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!transmit && cycles < 40);
        check({tag, "_seen"}, {31'd0, transmit}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    int cyc;
    int n;
    int hold;
    int tx_seen;
    int ack1_seen;
    int order [6] = '{0, 1, 2, 3, 0, 3};
    logic [3:0] exp_ack;

    initial begin
        rst       = 1'b1;
        req       = '0;
        req_data  = '0;
        req2      = '0;
        req_data2 = {8'h00, 8'h00, 8'h00, 8'h33};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_transmit", {31'd0, transmit}, 32'd0);
        check("rst_ack", {28'd0, ack}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_grant", {29'd0, grant_id}, 32'd0);
        rst = 1'b0;

        // Asynchronous reset in the middle of a frame (counter at 5)
        req      = 4'b0010;
        req_data = {8'h00, 8'h00, 8'h77, 8'h00};
        wait_tx("pre_rst", cyc);
        req = '0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_transmit", {31'd0, transmit}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_ack", {28'd0, ack}, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        req      = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h00, 8'h41};
        wait_tx("post_rst", cyc);
        check("post_rst_latency", cyc, 1);
        check("post_rst_tx_data", {24'd0, tx_data}, 32'h41);
        check("post_rst_ack", {28'd0, ack}, 32'h1);
        check("post_rst_grant", {29'd0, grant_id}, 32'd0);
        req = '0;

        // Requester 2 sends 0x5A: byte held through the frame, busy falls 11 cycles later
        req      = 4'b0100;
        req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        wait_tx("serial", cyc);
        check("serial_grant", {29'd0, grant_id}, 32'd2);
        check("serial_tx_data", {24'd0, tx_data}, 32'h5A);
        check("serial_busy_at_tx", {31'd0, busy}, 32'd1);
        req  = '0;
        n    = 0;
        hold = 0;
        do begin
            @(negedge clk);
            n++;
            if (n <= 10 && tx_data == 8'h5A && busy) hold++;
        end while (busy && n < 30);
        check("serial_hold", hold, 10);
        check("busy_fall", n, 11);

        // Round-robin order, spacing and pointer wrap
        do_reset();
        req      = 4'b1111;
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int k = 0; k < 6; k++) begin
            wait_tx($sformatf("rr%0d", k), cyc);
            if (k == 0) check("rr_latency", cyc, 1);
            else        check($sformatf("rr%0d_spacing", k), cyc, 12);
            exp_ack = 4'(1 << order[k]);
            check($sformatf("rr%0d_grant", k), {29'd0, grant_id}, order[k]);
            check($sformatf("rr%0d_tx_data", k), {24'd0, tx_data}, 32'hA0 + order[k]);
            check($sformatf("rr%0d_ack", k), {28'd0, ack}, {28'd0, exp_ack});
            if (k == 3) req = 4'b1001;
        end
        req = '0;
        repeat (15) @(negedge clk);

        // Request raised and dropped inside a frame is ignored
        do_reset();
        req      = 4'b0001;
        req_data = {8'h00, 8'h00, 8'h22, 8'h11};
        wait_tx("ign", cyc);
        check("ign_ack0", {28'd0, ack}, 32'h1);
        req = '0;
        repeat (2) @(negedge clk);
        req = 4'b0010;
        repeat (3) @(negedge clk);
        req       = '0;
        tx_seen   = 0;
        ack1_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (transmit) tx_seen++;
            if (ack[1])   ack1_seen++;
        end
        check("ign_no_transmit", tx_seen, 0);
        check("ign_no_ack1", ack1_seen, 0);
`ifdef UART_SCHED_STATS_EN
        check("ign_drop_cnt", {24'd0, drop_cnt}, 32'd1);
        check("ign_frames_sent", {16'd0, frames_sent}, 32'd1);
`endif

        // GAP=0 instance: continuous single requester every 11 cycles
        req2 = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!transmit2 && cyc < 40);
            check($sformatf("gap0_%0d_seen", k), {31'd0, transmit2}, 32'd1);
            if (k == 0) check("gap0_latency", cyc, 1);
            else        check($sformatf("gap0_%0d_spacing", k), cyc, 11);
            check($sformatf("gap0_%0d_ack", k), {28'd0, ack2}, 32'h1);
            check($sformatf("gap0_%0d_tx_data", k), {24'd0, tx_data2}, 32'h33);
        end
        req2 = '0;
        repeat (15) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
